// File: rtl/dm_pkg.sv
// dm_pkg: shared types and constants for the data-memory arbiter.
//   rtag_t : identifies which requester owns the read data returning
//            from memory in the current cycle.
//   DM_AW  : data-memory address width.
//   DM_DW  : data-memory data width.
package dm_pkg;

   localparam int unsigned DM_AW = 16;
   localparam int unsigned DM_DW = 16;

   typedef enum logic [1:0] {
      RTAG_NONE = 2'd0,
      RTAG_P    = 2'd1,
      RTAG_L    = 2'd2
   } rtag_t;

endpackage

// File: rtl/dm_arb_fair.sv
// dm_arb_fair: starvation guard for the loader port.
// Counts consecutive cycles in which the loader requests and loses. Once the
// count reaches MAX_WAIT, force_l is raised so the loader wins the next
// contested cycle. The count clears whenever the loader is granted or stops
// requesting.
// Only instantiated when DM_ARB_FAIR_EN is defined.
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous active-low reset
//   l_req   in   loader request
//   l_gnt   in   loader granted this cycle
//   force_l out  loader must win this cycle if it requests
module dm_arb_fair
#(
   parameter int unsigned MAX_WAIT = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic l_req,
   input  logic l_gnt,
   output logic force_l
);

   localparam logic [1:0] WAIT_LIM = 2'(MAX_WAIT);

   logic [1:0] cnt_r;
   logic [1:0] cnt_next_s;

   // Next value of the lost-cycle counter
   always_comb begin
      cnt_next_s = cnt_r;
      if (!l_req || l_gnt) begin
         cnt_next_s = 2'd0;
      end else if (cnt_r != WAIT_LIM) begin
         cnt_next_s = cnt_r + 2'd1;
      end else begin
         // Saturated: the override will grant L on its next request.
         cnt_next_s = cnt_r;
      end
   end

   // Lost-cycle counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r <= 2'd0;
      end else begin
         cnt_r <= cnt_next_s;
      end
   end

   // Override is a pure decode of the registered count, so it cannot loop
   // back through the grant logic combinationally.
   always_comb begin
      force_l = (cnt_r == WAIT_LIM);
   end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter for the single-ported data memory.
// The pipeline port (p_*) has priority over the loader port (l_*). Grant and
// stall are decided combinationally from the requests and registered state;
// the winner's access is forwarded straight to mem_*. A return tag remembers
// which port issued a read so that the data coming back one cycle later is
// steered to the right requester.
// Optional feature: define DM_ARB_FAIR_EN to add the loader starvation guard
// (dm_arb_fair); without it the pipeline has strict priority.
// Ports:
//   clk, reset                        clock, async active-low reset
//   p_req/p_we/p_addr/p_wdata         pipeline request
//   p_stall                           pipeline request not accepted
//   p_rdata/p_rvalid                  pipeline read return
//   l_req/l_we/l_addr/l_wdata         loader request
//   l_gnt                             loader request accepted
//   l_rdata/l_rvalid                  loader read return
//   mem_en/mem_we/mem_addr/mem_din    memory command
//   mem_dout                          memory read data (one cycle after read)
module dm_arbiter
   import dm_pkg::*;
#(
   parameter int unsigned AW       = DM_AW,
   parameter int unsigned DW       = DM_DW,
   parameter int unsigned MAX_WAIT = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          p_req,
   input  logic          p_we,
   input  logic [AW-1:0] p_addr,
   input  logic [DW-1:0] p_wdata,
   output logic          p_stall,
   output logic [DW-1:0] p_rdata,
   output logic          p_rvalid,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic          l_gnt,
   output logic [DW-1:0] l_rdata,
   output logic          l_rvalid,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   // The wait counter is two bits wide, so the limit must fit in it.
   if ((MAX_WAIT < 32'd1) || (MAX_WAIT > 32'd3)) begin : g_bad_max_wait
      $error("dm_arbiter: MAX_WAIT must be in 1..3");
   end

   logic          p_win_s;
   logic          l_win_s;
   logic          force_l_s;
   rtag_t         rtag_r;
   rtag_t         rtag_next_s;
   logic [DW-1:0] p_hold_r;
   logic [DW-1:0] l_hold_r;

`ifdef DM_ARB_FAIR_EN
   dm_arb_fair #(
      .MAX_WAIT (MAX_WAIT)
   ) u_fair (
      .clk     (clk),
      .reset   (reset),
      .l_req   (l_req),
      .l_gnt   (l_win_s),
      .force_l (force_l_s)
   );
`else
   assign force_l_s = 1'b0;
`endif

   // Winner selection; no grants while reset is asserted so memory stays idle
   always_comb begin
      p_win_s = 1'b0;
      l_win_s = 1'b0;
      if (!reset) begin
         p_win_s = 1'b0;
         l_win_s = 1'b0;
      end else if (p_req && !(force_l_s && l_req)) begin
         p_win_s = 1'b1;
      end else if (l_req) begin
         l_win_s = 1'b1;
      end else begin
         p_win_s = 1'b0;
         l_win_s = 1'b0;
      end
   end

   // Handshake outputs; stall is forced low during reset
   always_comb begin
      p_stall = reset & p_req & ~p_win_s;
      l_gnt   = l_win_s;
   end

   // Memory command mux and next return tag
   always_comb begin
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_din     = '0;
      rtag_next_s = RTAG_NONE;
      case ({p_win_s, l_win_s})
         2'b10: begin
            mem_en      = 1'b1;
            mem_we      = p_we;
            mem_addr    = p_addr;
            mem_din     = p_wdata;
            rtag_next_s = p_we ? RTAG_NONE : RTAG_P;
         end
         2'b01: begin
            mem_en      = 1'b1;
            mem_we      = l_we;
            mem_addr    = l_addr;
            mem_din     = l_wdata;
            rtag_next_s = l_we ? RTAG_NONE : RTAG_L;
         end
         default: begin
            mem_en      = 1'b0;
            mem_we      = 1'b0;
            mem_addr    = '0;
            mem_din     = '0;
            rtag_next_s = RTAG_NONE;
         end
      endcase
   end

   // Return tag and per-port read-data hold registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rtag_r   <= RTAG_NONE;
         p_hold_r <= '0;
         l_hold_r <= '0;
      end else begin
         rtag_r <= rtag_next_s;
         if (rtag_r == RTAG_P) begin
            p_hold_r <= mem_dout;
         end
         if (rtag_r == RTAG_L) begin
            l_hold_r <= mem_dout;
         end
      end
   end

   // Read return: during the tagged cycle memory data flows through; the
   // hold register keeps it visible until the next return to that port.
   always_comb begin
      p_rvalid = (rtag_r == RTAG_P);
      l_rvalid = (rtag_r == RTAG_L);
      if (p_rvalid) begin
         p_rdata = mem_dout;
      end else begin
         p_rdata = p_hold_r;
      end
      if (l_rvalid) begin
         l_rdata = mem_dout;
      end else begin
         l_rdata = l_hold_r;
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a write-first memory
// model and per-port scoreboard queues of expected read data.
module tb_dm_arbiter;
   import dm_pkg::*;

   localparam int unsigned AW = DM_AW;
   localparam int unsigned DW = DM_DW;

   logic          clk = 1'b0;
   logic          reset;
   logic          p_req, p_we, l_req, l_we;
   logic [AW-1:0] p_addr, l_addr;
   logic [DW-1:0] p_wdata, l_wdata;
   logic          p_stall, p_rvalid, l_gnt, l_rvalid;
   logic [DW-1:0] p_rdata, l_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   logic [DW-1:0] ram     [0:255];
   logic [DW-1:0] ref_mem [0:255];
   logic [DW-1:0] p_q [$];
   logic [DW-1:0] l_q [$];

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

`ifdef DM_ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   always #5 clk = ~clk;

   dm_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .p_req    (p_req),
      .p_we     (p_we),
      .p_addr   (p_addr),
      .p_wdata  (p_wdata),
      .p_stall  (p_stall),
      .p_rdata  (p_rdata),
      .p_rvalid (p_rvalid),
      .l_req    (l_req),
      .l_we     (l_we),
      .l_addr   (l_addr),
      .l_wdata  (l_wdata),
      .l_gnt    (l_gnt),
      .l_rdata  (l_rdata),
      .l_rvalid (l_rvalid),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   // Single-port write-first synchronous memory
   always @(posedge clk) begin
      if (mem_en === 1'b1) begin
         if (mem_we === 1'b1) begin
            ram[mem_addr[7:0]] <= mem_din;
            mem_dout <= mem_din;
         end else begin
            mem_dout <= ram[mem_addr[7:0]];
         end
      end
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every return pulse must match the oldest expected read
   always @(negedge clk) begin
      check("rvalid_exclusive", 16'(p_rvalid & l_rvalid), 16'd0);
      if (p_rvalid === 1'b1) begin
         if (p_q.size() == 0) check("p_rvalid_unexpected", 16'(p_rvalid), 16'd0);
         else check("p_rdata", p_rdata, p_q.pop_front());
      end
      if (l_rvalid === 1'b1) begin
         if (l_q.size() == 0) check("l_rvalid_unexpected", 16'(l_rvalid), 16'd0);
         else check("l_rdata", l_rdata, l_q.pop_front());
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]     = 16'(i) ^ 16'hC3C3;
         ref_mem[i] = 16'(i) ^ 16'hC3C3;
      end
      mem_dout = 16'd0;
      reset = 1'b0;
      p_req = 1'b1; p_we = 1'b0; p_addr = 16'h0005; p_wdata = 16'd0;
      l_req = 1'b0; l_we = 1'b0; l_addr = 16'd0;    l_wdata = 16'd0;

      // Reset held with a pending pipeline request
      @(negedge clk);
      check("rst_mem_en",   16'(mem_en),   16'd0);
      check("rst_p_stall",  16'(p_stall),  16'd0);
      check("rst_l_gnt",    16'(l_gnt),    16'd0);
      check("rst_p_rvalid", 16'(p_rvalid), 16'd0);
      check("rst_l_rvalid", 16'(l_rvalid), 16'd0);
      check("rst_p_rdata",  p_rdata,       16'd0);
      check("rst_l_rdata",  l_rdata,       16'd0);

      // Release: the held read proceeds
      next_cycle();
      reset = 1'b1;
      p_q.push_back(ref_mem[8'h05]);
      @(negedge clk);
      check("rel_mem_en",   16'(mem_en),  16'd1);
      check("rel_mem_addr", mem_addr,     16'h0005);
      check("rel_p_stall",  16'(p_stall), 16'd0);

      // Idle cycle: memory bus quiet
      next_cycle();
      p_req = 1'b0;
      @(negedge clk);
      check("idle_mem_en",   16'(mem_en), 16'd0);
      check("idle_mem_we",   16'(mem_we), 16'd0);
      check("idle_mem_addr", mem_addr,    16'd0);
      check("idle_mem_din",  mem_din,     16'd0);

      // P write 0x00A5 <- 0xBEEF
      next_cycle();
      p_req = 1'b1; p_we = 1'b1; p_addr = 16'h00A5; p_wdata = 16'hBEEF;
      ref_mem[8'hA5] = 16'hBEEF;
      @(negedge clk);
      check("wr_mem_we",   16'(mem_we),  16'd1);
      check("wr_mem_addr", mem_addr,     16'h00A5);
      check("wr_mem_din",  mem_din,      16'hBEEF);
      check("wr_p_stall",  16'(p_stall), 16'd0);

      // P read back the same address next cycle
      next_cycle();
      p_we = 1'b0; p_wdata = 16'd0;
      p_q.push_back(ref_mem[8'hA5]);
      @(negedge clk);
      check("rd_mem_we",  16'(mem_we),  16'd0);
      check("rd_p_stall", 16'(p_stall), 16'd0);

      next_cycle();
      p_req = 1'b0;
      @(negedge clk);
      check("rd_p_rvalid", 16'(p_rvalid), 16'd1);

      next_cycle();
      @(negedge clk);
      check("rd_p_rvalid_end", 16'(p_rvalid), 16'd0);
      check("rd_p_rdata_hold", p_rdata,       16'hBEEF);

      // Interleaved reads: P 0x0010 wins, L 0x0020 waits for the idle-P cycle
      next_cycle();
      p_req = 1'b1; p_addr = 16'h0010;
      l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0020;
      p_q.push_back(ref_mem[8'h10]);
      @(negedge clk);
      check("il_l_gnt0",   16'(l_gnt),   16'd0);
      check("il_p_stall0", 16'(p_stall), 16'd0);
      check("il_addr0",    mem_addr,     16'h0010);

      next_cycle();
      p_req = 1'b0;
      l_q.push_back(ref_mem[8'h20]);
      @(negedge clk);
      check("il_l_gnt1",    16'(l_gnt),    16'd1);
      check("il_addr1",     mem_addr,      16'h0020);
      check("il_p_rvalid1", 16'(p_rvalid), 16'd1);
      check("il_l_rvalid1", 16'(l_rvalid), 16'd0);

      next_cycle();
      l_req = 1'b0;
      @(negedge clk);
      check("il_l_rvalid2", 16'(l_rvalid), 16'd1);
      check("il_p_rvalid2", 16'(p_rvalid), 16'd0);

      next_cycle();

      // Continuous contention
      for (int i = 0; i < 20; i++) begin
         logic exp_l;
         next_cycle();
         exp_l = FAIR && ((i % 4) == 3);
         p_req = 1'b1; p_we = 1'b0; p_addr = 16'h0030 + 16'(i);
         l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0060 + 16'(i);
         if (exp_l) l_q.push_back(ref_mem[8'h60 + 8'(i)]);
         else       p_q.push_back(ref_mem[8'h30 + 8'(i)]);
         @(negedge clk);
         check($sformatf("ct_l_gnt_%0d", i),   16'(l_gnt),   16'(exp_l));
         check($sformatf("ct_p_stall_%0d", i), 16'(p_stall), 16'(exp_l));
      end

      next_cycle();
      p_req = 1'b0; l_req = 1'b0;
      next_cycle();
      next_cycle();

      // Reset during an outstanding L read
      l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0021;
      @(negedge clk);
      check("mr_l_gnt", 16'(l_gnt), 16'd1);
      next_cycle();
      l_req = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check("mr_l_rvalid", 16'(l_rvalid), 16'd0);
      check("mr_l_rdata",  l_rdata,       16'd0);
      next_cycle();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("mr_post_l_rvalid", 16'(l_rvalid), 16'd0);
         check("mr_post_l_rdata",  l_rdata,       16'd0);
         next_cycle();
      end

      check("p_queue_drained", 16'(p_q.size()), 16'd0);
      check("l_queue_drained", 16'(l_q.size()), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
